bcd_seq_convert_ctrl: RTL and testbench

//  Sequential controller for a signed binary-to-BCD conversion, built on shift-add-3 (double dabble).

---
 rtl/bcd_seq_convert_ctrl_if.sv | 37 +++
 rtl/bcd_seq_convert_ctrl.sv | 115 +++++++++++
 tb/tb_bcd_seq_convert_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_seq_convert_ctrl_if.sv
// Handshake bundle between a binary requester/consumer and the sequential BCD converter.
// The master side supplies operands and takes results; the slave side is the converter.
interface bcd_seq_convert_ctrl_if #(
    parameter int DATA_W   = 16,
    parameter int N_DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     dec_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*N_DIGITS-1:0] bcd_out;
    logic                  sign_out;
    logic                  busy;

    modport master (
        output in_valid,
        output dec_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bcd_out,
        input  sign_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  dec_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bcd_out,
        output sign_out,
        output busy
    );
endinterface

// File: rtl/bcd_seq_convert_ctrl.sv
// Signed (one's-complement) binary to sign + packed BCD converter using shift-add-3,
// one magnitude bit per clock, with valid/ready handshakes on both sides.
module bcd_seq_convert_ctrl #(
    parameter int DATA_W   = 16,
    parameter int N_DIGITS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_seq_convert_ctrl_if.slave  bus
);
    localparam int MAG_W = DATA_W - 1;
    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [BCD_W-1:0]   bcdOut_q, bcdOut_d;
    logic               signOut_q, signOut_d;

    logic [MAG_W-1:0]   inMag;
    logic [BCD_W-1:0]   accAdj;
    logic [BCD_W-1:0]   accShift;

    // Negative one's-complement values carry their magnitude inverted.
    always_comb begin
        inMag = bus.dec_in[DATA_W-1] ? ~bus.dec_in[MAG_W-1:0] : bus.dec_in[MAG_W-1:0];
    end

    always_comb begin
        accAdj = acc_q;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) begin
                accAdj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
            end
        end
        accShift = {accAdj[BCD_W-2:0], mag_q[MAG_W-1]};
    end

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        bcdOut_d  = bcdOut_q;
        signOut_d = signOut_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mag_d   = inMag;
                    sign_d  = bus.dec_in[DATA_W-1] & (|inMag);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = accShift;
                mag_d = mag_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                // Last step publishes the freshly shifted accumulator directly.
                if (cnt_q == CNT_W'(DATA_W - 2)) begin
                    bcdOut_d  = accShift;
                    signOut_d = sign_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            bcdOut_q  <= '0;
            signOut_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            bcdOut_q  <= bcdOut_d;
            signOut_q <= signOut_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == SHIFT);
    assign bus.bcd_out   = bcdOut_q;
    assign bus.sign_out  = signOut_q;

endmodule

// File: tb/tb_bcd_seq_convert_ctrl.sv
// Directed and randomised checks of the sequential BCD converter against a
// divide-by-ten reference, including back-pressure, reset abort and spacing.
module tb_bcd_seq_convert_ctrl;
    localparam int DATA_W   = 16;
    localparam int N_DIGITS = 5;
    localparam int BCD_W    = 4 * N_DIGITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assertCount = 0;
    int   failCount   = 0;
    int   cycleCount  = 0;

    bcd_seq_convert_ctrl_if #(.DATA_W(DATA_W), .N_DIGITS(N_DIGITS)) bus ();

    bcd_seq_convert_ctrl #(.DATA_W(DATA_W), .N_DIGITS(N_DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [BCD_W-1:0] refBcd(input int unsigned value);
        logic [BCD_W-1:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int i = 0; i < N_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int unsigned refMag(input logic [DATA_W-1:0] word);
        logic [DATA_W-2:0] m;
        m = word[DATA_W-1] ? ~word[DATA_W-2:0] : word[DATA_W-2:0];
        return int'(m);
    endfunction

    // Presents a word and waits (bounded) for the accept edge; returns at #1 after it.
    task automatic applyStimulus(input logic [DATA_W-1:0] word, input bit keepValid, output int acceptCycle);
        bit accepted;
        accepted    = 1'b0;
        acceptCycle = 0;
        bus.dec_in   = word;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 64 && !accepted; i++) begin
            if (bus.in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        acceptCycle = cycleCount;
        if (!keepValid) bus.in_valid = 1'b0;
        if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 64) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!bus.out_valid) checkOutput("resultTimeout", 32'd0, 32'd1);
    endtask

    task automatic runOne(input string tag, input logic [DATA_W-1:0] word,
                          input logic [BCD_W-1:0] expBcd, input logic expSign);
        int acc;
        int cyc;
        applyStimulus(word, 1'b0, acc);
        waitResult(cyc);
        checkOutput({tag, "_bcd"}, 32'(bus.bcd_out), 32'(expBcd));
        checkOutput({tag, "_sign"}, 32'(bus.sign_out), 32'(expSign));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int cyc;
        int prevAccept;
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] nextWord;

        bus.in_valid  = 1'b0;
        bus.dec_in    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_bcd", 32'(bus.bcd_out), 32'd0);
        checkOutput("rst_sign", 32'(bus.sign_out), 32'd0);

        $display("[TB] zero operand and latency");
        applyStimulus(16'h0000, 1'b0, acc);
        checkOutput("shift_busy", 32'(bus.busy), 32'd1);
        checkOutput("shift_in_ready", 32'(bus.in_ready), 32'd0);
        waitResult(cyc);
        checkOutput("latency", 32'(cyc), 32'd15);
        checkOutput("zero_bcd", 32'(bus.bcd_out), 32'h00000);
        checkOutput("zero_sign", 32'(bus.sign_out), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] range limits and negative zero");
        runOne("max_pos", 16'h7FFF, 20'h32767, 1'b0);
        checkOutput("hold_after_done", 32'(bus.bcd_out), 32'h32767);
        runOne("max_neg", 16'h8000, 20'h32767, 1'b1);
        runOne("neg_zero", 16'hFFFF, 20'h00000, 1'b0);
        runOne("neg_nine", 16'hFFF6, 20'h00009, 1'b1);
        runOne("ten_k", 16'h2710, 20'h10000, 1'b0);
        runOne("digits", 16'd9999, 20'h09999, 1'b0);

        $display("[TB] back-pressure");
        bus.out_ready = 1'b0;
        applyStimulus(16'd1234, 1'b0, acc);
        waitResult(cyc);
        checkOutput("bp_bcd", 32'(bus.bcd_out), 32'h01234);
        bus.in_valid = 1'b1;
        bus.dec_in   = 16'd5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("bp_bcd_hold", 32'(bus.bcd_out), 32'h01234);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;

        $display("[TB] reset during conversion");
        applyStimulus(16'd999, 1'b0, acc);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_bcd", 32'(bus.bcd_out), 32'd0);
        runOne("after_abort", 16'd42, 20'h00042, 1'b0);

        $display("[TB] back-to-back random words");
        bus.out_ready = 1'b1;
        prevAccept = 0;
        word = DATA_W'($urandom);
        for (int n = 0; n < 500; n++) begin
            applyStimulus(word, 1'b1, acc);
            if (n > 0) checkOutput("spacing", 32'(acc - prevAccept), 32'd17);
            prevAccept = acc;
            nextWord = DATA_W'($urandom);
            bus.dec_in = nextWord;
            waitResult(cyc);
            checkOutput("rand_bcd", 32'(bus.bcd_out), 32'(refBcd(refMag(word))));
            checkOutput("rand_sign", 32'(bus.sign_out),
                        32'(word[DATA_W-1] && (refMag(word) != 0)));
            word = nextWord;
        end
        bus.in_valid = 1'b0;

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
